// File: rtl/hidden_neuron_pkg.sv
// hidden_neuron_pkg
// Shared definitions for the hidden neuron and later network layers:
// default word/fraction widths, Q8.24 constants, FSM state encoding
// and weight-register address codes.
package hidden_neuron_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int FRAC_DEF   = 24;

    // Fixed-point constants in the default Q8.24 format.
    localparam logic signed [DWIDTH_DEF-1:0] ONE     = 32'sh0100_0000;
    localparam logic signed [DWIDTH_DEF-1:0] HALF    = 32'sh0080_0000;
    localparam logic signed [DWIDTH_DEF-1:0] TWO     = 32'sh0200_0000;
    localparam logic signed [DWIDTH_DEF-1:0] NEG_TWO = 32'shFE00_0000;
    localparam logic signed [DWIDTH_DEF-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [DWIDTH_DEF-1:0] SAT_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_W1   = 2'd0;
    localparam logic [1:0] ADDR_W2   = 2'd1;
    localparam logic [1:0] ADDR_BIAS = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

endpackage

// File: rtl/hidden_neuron_if.sv
// hidden_neuron_if
// Bundles the neuron's data handshakes and weight-write bus.
//   in_valid/in_ready/A/B       : input stage -> neuron
//   w_we/w_addr/w_data          : weight/bias write port
//   out_valid/out_ready/out     : neuron -> downstream
// Handshake rule (both directions): a transfer happens on the rising edge
// where valid && ready are both 1; the source holds its payload stable while
// valid is high and ready is low, and the sink may not depend on a
// combinational path from valid to ready.
interface hidden_neuron_if
    import hidden_neuron_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] A;
    logic signed [DWIDTH-1:0] B;
    logic                     w_we;
    logic [1:0]               w_addr;
    logic signed [DWIDTH-1:0] w_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out;

    modport master (
        output in_valid, A, B, w_we, w_addr, w_data, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, A, B, w_we, w_addr, w_data, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fxp_mul_sat.sv
// fxp_mul_sat
// Signed fixed-point multiply: full 2*DWIDTH product, arithmetic shift
// right by FRAC, saturated back into DWIDTH bits.
//   i_a, i_b : signed operands (DWIDTH)
//   o_p      : saturated, rescaled product (DWIDTH)
module fxp_mul_sat #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24
) (
    input  logic signed [DWIDTH-1:0] i_a,
    input  logic signed [DWIDTH-1:0] i_b,
    output logic signed [DWIDTH-1:0] o_p
);
    logic signed [2*DWIDTH-1:0] w_a_ext;
    logic signed [2*DWIDTH-1:0] w_b_ext;
    logic signed [2*DWIDTH-1:0] w_prod;
    logic signed [2*DWIDTH-1:0] w_shift;
    logic [DWIDTH:0]            w_hi;

    assign w_a_ext = {{DWIDTH{i_a[DWIDTH-1]}}, i_a};
    assign w_b_ext = {{DWIDTH{i_b[DWIDTH-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_shift = w_prod >>> FRAC;
    // The result fits in DWIDTH bits only if every bit from the DWIDTH-1
    // position upward is a copy of the sign.
    assign w_hi    = w_shift[2*DWIDTH-1:DWIDTH-1];

    always_comb begin
        o_p = w_shift[DWIDTH-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
            o_p = w_hi[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}}
                               : {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end
endmodule

// File: rtl/hidden_neuron.sv
// hidden_neuron
// One hidden-layer neuron: out = hard_sigmoid(bias + w1*A + w2*B) in
// signed fixed point, using a single shared multiplier over two cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hidden_neuron_if.slave (input handshake, weight writes,
//              output handshake)
//   o_state  : current FSM state, for observation only
module hidden_neuron
    import hidden_neuron_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int frac   = FRAC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    hidden_neuron_if.slave bus,
    output state_t         o_state
);
    state_t r_state;
    state_t w_next_state;

    logic signed [DWIDTH-1:0] r_w1, r_w2, r_bias;
    logic signed [DWIDTH-1:0] r_acc, r_a, r_b, r_out;
    logic signed [DWIDTH-1:0] w_mul_a, w_mul_b, w_prod;
    logic signed [DWIDTH-1:0] w_addend, w_sum_sat, w_act;
    logic signed [DWIDTH:0]   w_sum_wide;
    logic                     w_in_mul1;

    assign w_in_mul1 = (r_state == S_MUL1);

    // MUL1 uses (w1, A) on top of bias; MUL2 uses (w2, B) on top of acc.
    assign w_mul_a  = w_in_mul1 ? r_w1   : r_w2;
    assign w_mul_b  = w_in_mul1 ? r_a    : r_b;
    assign w_addend = w_in_mul1 ? r_bias : r_acc;

    fxp_mul_sat #(
        .DWIDTH (DWIDTH),
        .FRAC   (frac)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    // One guard bit: overflow shows as the top two bits disagreeing.
    assign w_sum_wide = {w_addend[DWIDTH-1], w_addend} + {w_prod[DWIDTH-1], w_prod};

    always_comb begin
        w_sum_sat = w_sum_wide[DWIDTH-1:0];
        if (w_sum_wide[DWIDTH] != w_sum_wide[DWIDTH-1]) begin
            w_sum_sat = w_sum_wide[DWIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // Hard sigmoid: linear 0.5 + acc/4 between -2.0 and 2.0, clamped outside.
    always_comb begin
        w_act = HALF + (r_acc >>> 2);
        if (r_acc >= TWO) begin
            w_act = ONE;
        end else if (r_acc <= NEG_TWO) begin
            w_act = '0;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next_state = S_MUL1;
            end
            S_MUL1: w_next_state = S_MUL2;
            S_MUL2: w_next_state = S_ACT;
            S_ACT:  w_next_state = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w1    <= ONE;
            r_w2    <= ONE;
            r_bias  <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            // Weights are only writable while idle; a write on the accepting
            // edge lands before MUL1 reads it.
            if (r_state == S_IDLE && bus.w_we) begin
                case (bus.w_addr)
                    ADDR_W1:   r_w1   <= bus.w_data;
                    ADDR_W2:   r_w2   <= bus.w_data;
                    ADDR_BIAS: r_bias <= bus.w_data;
                    default:   ;
                endcase
            end
            if (r_state == S_IDLE && bus.in_valid) begin
                r_a <= bus.A;
                r_b <= bus.B;
            end
            if (r_state == S_MUL1 || r_state == S_MUL2) begin
                r_acc <= w_sum_sat;
            end
            if (r_state == S_ACT) begin
                r_out <= w_act;
            end
        end
    end

    assign bus.out = r_out;
    assign o_state = r_state;
endmodule

// File: tb/tb_hidden_neuron.sv
// tb_hidden_neuron
// Self-checking bench for hidden_neuron: directed vectors with known
// results plus randomized transactions against an arithmetic model.
module tb_hidden_neuron;
    import hidden_neuron_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    always #5 clk = ~clk;

    hidden_neuron_if #(.DWIDTH(32)) bus ();

    hidden_neuron #(.DWIDTH(32), .frac(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_w1, m_w2, m_bias;
    localparam longint L_MAX = 64'sd2147483647;
    localparam longint L_MIN = -L_MAX - 1;

    function automatic longint clamp(input longint v);
        if (v > L_MAX) return L_MAX;
        if (v < L_MIN) return L_MIN;
        return v;
    endfunction

    function automatic longint fx_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return clamp(p >>> FRAC_DEF);
    endfunction

    function automatic logic [31:0] model_out(input logic [31:0] a, input logic [31:0] b);
        longint acc;
        longint two;
        logic [63:0] r;
        acc = clamp(longint'($signed(m_bias)) + fx_mul(m_w1, a));
        acc = clamp(acc + fx_mul(m_w2, b));
        two = longint'(1) <<< (FRAC_DEF + 1);
        if (acc >= two) return 32'h0100_0000;
        if (acc <= -two) return 32'h0000_0000;
        r = (longint'(1) <<< (FRAC_DEF - 1)) + (acc >>> 2);
        return r[31:0];
    endfunction

    function automatic void model_write(input logic [1:0] addr, input logic [31:0] data);
        case (addr)
            2'd0: m_w1 = data;
            2'd1: m_w2 = data;
            2'd2: m_bias = data;
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        m_w1   = 32'h0100_0000;
        m_w2   = 32'h0100_0000;
        m_bias = 32'h0000_0000;
        exp_q.delete();
    endfunction

    function automatic logic [31:0] rand_val();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_w(input logic [1:0] addr, input logic [31:0] data);
        bus.w_we   = 1'b1;
        bus.w_addr = addr;
        bus.w_data = data;
        @(negedge clk);
        bus.w_we = 1'b0;
        model_write(addr, data);
    endtask

    // Called at a negedge with the DUT idle. Runs one full transaction,
    // optionally with a write on the accepting edge, a dropped write in
    // MUL1, and a back-pressure hold in DONE. Returns the observed output.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input bit co_we, input logic [1:0] co_addr,
                           input logic [31:0] co_data, input bit busy_write,
                           input int hold_cycles, output logic [31:0] got);
        logic [31:0] exp_v;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        if (co_we) begin
            bus.w_we   = 1'b1;
            bus.w_addr = co_addr;
            bus.w_data = co_data;
            model_write(co_addr, co_data);
        end
        exp_q.push_back(model_out(a, b));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.w_we     = 1'b0;
        if (busy_write) begin
            bus.w_we   = 1'b1;
            bus.w_addr = ADDR_W1;
            bus.w_data = 32'h0300_0000;
        end
        for (int k = 0; k < 3; k++) begin
            check("lat_lo", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            bus.w_we = 1'b0;
        end
        check("lat_hi", 32'(bus.out_valid), 32'd1);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        got = bus.out;
        check("out", bus.out, exp_v);
        bus.in_valid = (hold_cycles > 0);
        bus.A = $urandom;
        bus.B = $urandom;
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out", bus.out, exp_v);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("ret_idle", 32'(dbg_state), 32'(S_IDLE));
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("out_keep", bus.out, exp_v);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, output logic [31:0] got);
        run_txn(a, b, 1'b0, 2'd0, 32'd0, 1'b0, 0, got);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.out_ready = 1'b0;
        model_reset();

        do_reset();
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", bus.out, 32'd0);

        // Default weights: 1.0 + 0.5 -> 0.875
        txn(32'h0100_0000, 32'h0080_0000, r);
        check("dir_default", r, 32'h00E0_0000);

        // Custom weights: 0.25 + 1.0 - 1.0 -> 0.5625
        write_w(ADDR_W1, 32'h0200_0000);
        write_w(ADDR_W2, 32'hFF00_0000);
        write_w(ADDR_BIAS, 32'h0040_0000);
        txn(32'h0080_0000, 32'h0100_0000, r);
        check("dir_custom", r, 32'h0090_0000);

        // Reset while in MUL2 discards the transaction and restores weights.
        bus.in_valid = 1'b1;
        bus.A = 32'h0100_0000;
        bus.B = 32'h0100_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_mul2", 32'(dbg_state), 32'(S_MUL2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out", bus.out, 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        txn(32'h0100_0000, 32'h0080_0000, r);
        check("dir_weights_restored", r, 32'h00E0_0000);

        // Saturating product, acc exactly 2.0, strongly negative acc.
        write_w(ADDR_W1, 32'h7F00_0000);
        txn(32'h7F00_0000, 32'h0000_0000, r);
        check("dir_prod_sat", r, 32'h0100_0000);
        write_w(ADDR_W1, 32'h0100_0000);
        txn(32'h0100_0000, 32'h0100_0000, r);
        check("dir_acc_two", r, 32'h0100_0000);
        txn(32'hFD00_0000, 32'h0000_0000, r);
        check("dir_neg", r, 32'h0000_0000);

        // Write during MUL1 is dropped; the next transaction proves it.
        run_txn(32'h0100_0000, 32'h0000_0000, 1'b0, 2'd0, 32'd0, 1'b1, 0, r);
        check("dir_busy_write", r, 32'h00C0_0000);
        txn(32'h0100_0000, 32'h0000_0000, r);
        check("dir_after_busy", r, 32'h00C0_0000);

        // Back-pressure: hold DONE for 10 cycles with in_valid asserted.
        run_txn(32'h0100_0000, 32'h0080_0000, 1'b0, 2'd0, 32'd0, 1'b0, 10, r);
        check("dir_hold", r, 32'h00E0_0000);

        // Write on the accepting edge is used by that transaction.
        run_txn(32'h0100_0000, 32'h0000_0000, 1'b1, ADDR_W1, 32'h0080_0000, 1'b0, 0, r);
        check("dir_cowrite", r, 32'h00A0_0000);

        // Reserved address is ignored.
        write_w(ADDR_RSVD, 32'h7FFF_FFFF);
        txn(32'h0100_0000, 32'h0000_0000, r);
        check("dir_rsvd", r, 32'h00A0_0000);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                write_w(2'($urandom_range(0, 3)), rand_val());
            end
            run_txn(rand_val(), rand_val(), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), rand_val(),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hidden_neuron.md
HIDDEN_NEURON -- requirements
Module: hidden_neuron

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data word width, signed fixed point.
REQ-002 SHALL have parameter frac, default 24, fractional bits (Q8.24 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  A/B offered by upstream input stage.
REQ-006 SHALL have port in_ready  output  1  neuron can accept A/B.
REQ-007 SHALL have ports A, B  input  DWIDTH signed  the two network inputs.
REQ-008 SHALL have port w_we  input  1  weight/bias write strobe.
REQ-009 SHALL have port w_addr  input  2  0=w1, 1=w2, 2=bias, 3=reserved.
REQ-010 SHALL have port w_data  input  DWIDTH signed  value to write.
REQ-011 SHALL have port out_valid  output  1  activation result available.
REQ-012 SHALL have port out_ready  input  1  downstream consumes result.
REQ-013 SHALL have port out  output  DWIDTH signed  activation result.

Function
REQ-014 SHALL implement FSM IDLE -> MUL1 -> MUL2 -> ACT -> DONE -> IDLE, one shared multiplier.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept on edge with in_valid&&in_ready, latching A and B; IDLE->MUL1.
REQ-016 MUL1 SHALL set acc = sat(bias + sat((w1*A)>>>frac)); ->MUL2.
REQ-017 MUL2 SHALL set acc = sat(acc + sat((w2*B)>>>frac)); ->ACT.
REQ-018 Products SHALL be 2*DWIDTH signed, arithmetic-shifted by frac, saturated to [0x80000000, 0x7FFFFFFF]; each sum computed at DWIDTH+1 bits and saturated likewise.
REQ-019 ACT SHALL register out = hard sigmoid(acc): acc >= 2.0 -> 1.0 (0x01000000); acc <= -2.0 -> 0; else 0x00800000 + (acc>>>2); ->DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE: first high in the cycle after the 4th rising edge counting the accepting edge.
REQ-021 In DONE, out and out_valid SHALL hold stable while out_ready=0; on edge with out_ready=1, ->IDLE, out_valid=0, out retains last value.
REQ-022 No bypass: a new input is accepted only in IDLE, minimum 5 cycles per transaction.
REQ-023 Weight writes SHALL take effect on the edge with w_we=1 only when state is IDLE; writes in other states and writes to w_addr=3 SHALL be dropped.
REQ-024 Simultaneous w_we and input accept in IDLE: the write SHALL complete, and the accepted transaction SHALL use the newly written value.

Reset
REQ-025 On rst=1 at an edge, from any state: state=IDLE, out=0, out_valid=0, acc=0, latched A/B=0.
REQ-026 Reset SHALL set w1=w2=1.0 (0x01000000) and bias=0; a transaction in progress SHALL be discarded with no output.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold DWIDTH/frac defaults, constants ONE, HALF, TWO, NEG_TWO, SAT_MAX, SAT_MIN, the FSM state encoding, and w_addr codes.
REQ-029 Fixed-point multiply-shift-saturate SHALL be one sub-module, fxp_mul_sat, reused by later layers; activation stays inline.

Verification
REQ-030 After reset, default weights, A=0x01000000, B=0x00800000 -> out=0x00E00000, out_valid high in the cycle after the 4th edge counting the accepting edge.
REQ-031 Write w1=0x02000000, w2=0xFF000000, bias=0x00400000; A=0x00800000, B=0x01000000 -> out=0x00900000.
REQ-032 w1=0x7F000000, A=0x7F000000 (product saturates) -> out=0x01000000; acc exactly 2.0 -> 0x01000000; A=0xFD000000 with defaults and B=0 -> out=0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out/out_valid stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-034 Assert rst during MUL2 after loading custom weights -> next cycle IDLE, out_valid=0, out=0, weights back to 1.0/1.0/0.
REQ-035 w_we during MUL1 with w_addr=0 -> w1 unchanged, observed by a following transaction's result.
